irq_controller: RTL and testbench

//  Memory-mapped interrupt controller downstream of Timer and the other peripherals.

---
 rtl/irq_controller.sv | 142 ++++++++++++++
 tb/tb_irq_controller.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/irq_controller.sv
// ---------------------------------------------------------------------------
// irq_controller
//   Memory-mapped interrupt controller. It latches peripheral interrupt lines
//   into pending bits, masks them with per-source enables and drives a single
//   registered CPU interrupt request. A claim/complete register pair hands out
//   the highest-priority (lowest index) active source and tracks which sources
//   are currently being serviced.
//
// Ports
//   clk      in   1            system clock, rising edge
//   rst      in   1            asynchronous active-low reset
//   address  in   32           register byte address, only [4:0] decoded
//   wr_en    in   1            single-cycle register write strobe
//   rd_en    in   1            single-cycle register read strobe
//   wr_data  in   32           write data
//   rd_data  out  32           combinational read data, 0 when rd_en=0
//   irq_src  in   NUM_SOURCES  peripheral interrupt lines (bit 0 = Timer)
//   irq_out  out  1            registered interrupt request to the CPU
//
// Register map (NUM_SOURCES wide, upper bits read 0)
//   0x00 ENABLE RW | 0x04 TRIGGER RW (1=edge) | 0x08 PENDING R/W1C
//   0x0C CLAIM R (read claims) | 0x10 COMPLETE W | 0x14 INSERV R
// ---------------------------------------------------------------------------
module irq_controller #(
  parameter int NUM_SOURCES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [31:0]            address,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [31:0]            wr_data,
  output logic [31:0]            rd_data,
  input  logic [NUM_SOURCES-1:0] irq_src,
  output logic                   irq_out
);

  localparam int N    = NUM_SOURCES;
  localparam int ID_W = 5;  // claim ids 0..31

  localparam logic [4:0] ADDR_ENABLE   = 5'h00;
  localparam logic [4:0] ADDR_TRIGGER  = 5'h04;
  localparam logic [4:0] ADDR_PENDING  = 5'h08;
  localparam logic [4:0] ADDR_CLAIM    = 5'h0C;
  localparam logic [4:0] ADDR_COMPLETE = 5'h10;
  localparam logic [4:0] ADDR_INSERV   = 5'h14;

  logic [N-1:0]    r_enable;
  logic [N-1:0]    r_trigger;
  logic [N-1:0]    r_pending;
  logic [N-1:0]    r_inserv;
  logic [N-1:0]    r_src_q;
  logic            r_irq_out;

  logic [4:0]      w_sel;
  logic [N-1:0]    w_active;
  logic [ID_W-1:0] w_best_id;
  logic            w_claim;
  logic            w_complete_hit;
  logic            w_w1c;
  logic [N-1:0]    w_pend_set;
  logic [N-1:0]    w_claim_mask;
  logic [N-1:0]    w_complete_mask;
  logic [N-1:0]    w_pending_next;
  logic [N-1:0]    w_inserv_next;
  logic            w_unused_addr;

  assign w_sel         = address[4:0];
  assign w_unused_addr = ^address[31:5];

  assign w_active = r_pending & r_enable & ~r_inserv;

  // Lowest set index wins: scan downwards so the last hit is the smallest.
  always_comb begin
    w_best_id = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (w_active[i]) w_best_id = ID_W'(i + 1);
    end
  end

  // A claim only has side effects when there is something to claim.
  assign w_claim        = rd_en && (w_sel == ADDR_CLAIM) && (w_best_id != '0);
  assign w_w1c          = wr_en && (w_sel == ADDR_PENDING);
  assign w_complete_hit = wr_en && (w_sel == ADDR_COMPLETE);

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_src
      // Edge mode looks for a fresh rising edge; level mode re-pends while the
      // line is high, but not while that source is being serviced.
      assign w_pend_set[gi] = r_trigger[gi] ? (irq_src[gi] & ~r_src_q[gi])
                                            : (irq_src[gi] & ~r_inserv[gi]);

      assign w_claim_mask[gi]    = w_claim && (w_best_id == ID_W'(gi + 1));
      // Full 32-bit compare so out-of-range ids (0, >N) match no source.
      assign w_complete_mask[gi] = w_complete_hit && (wr_data == 32'(gi + 1));

      // Clears first, then set: a new event in the same cycle is never lost.
      assign w_pending_next[gi] = (r_pending[gi]
                                   & ~(w_w1c & wr_data[gi])
                                   & ~w_claim_mask[gi])
                                  | w_pend_set[gi];

      assign w_inserv_next[gi] = (r_inserv[gi] & ~w_complete_mask[gi])
                                 | w_claim_mask[gi];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_enable  <= '0;
      r_trigger <= '0;
      r_pending <= '0;
      r_inserv  <= '0;
      r_src_q   <= '0;
      r_irq_out <= 1'b0;
    end else begin
      if (wr_en && (w_sel == ADDR_ENABLE))  r_enable  <= wr_data[N-1:0];
      if (wr_en && (w_sel == ADDR_TRIGGER)) r_trigger <= wr_data[N-1:0];
      r_pending <= w_pending_next;
      r_inserv  <= w_inserv_next;
      r_src_q   <= irq_src;
      r_irq_out <= |w_active;
    end
  end

  assign irq_out = r_irq_out;

  always_comb begin
    rd_data = '0;
    if (rd_en) begin
      case (w_sel)
        ADDR_ENABLE:  rd_data = 32'(r_enable);
        ADDR_TRIGGER: rd_data = 32'(r_trigger);
        ADDR_PENDING: rd_data = 32'(r_pending);
        ADDR_CLAIM:   rd_data = 32'(w_best_id);
        ADDR_INSERV:  rd_data = 32'(r_inserv);
        default:      rd_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_irq_controller.sv
`timescale 1ns/100ps
module tb_irq_controller;

  localparam logic [31:0] A_EN = 32'h00;
  localparam logic [31:0] A_TR = 32'h04;
  localparam logic [31:0] A_PD = 32'h08;
  localparam logic [31:0] A_CL = 32'h0C;
  localparam logic [31:0] A_CO = 32'h10;
  localparam logic [31:0] A_IS = 32'h14;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] address = '0;
  logic        wr_en = 1'b0;
  logic        rd_en = 1'b0;
  logic [31:0] wr_data = '0;
  logic [31:0] rd_data;
  logic [7:0]  irq_src = '0;
  logic        irq_out;

  int n_tests = 0;
  int n_fail  = 0;

  irq_controller #(.NUM_SOURCES(8)) dut (
    .clk     (clk),
    .rst     (rst),
    .address (address),
    .wr_en   (wr_en),
    .rd_en   (rd_en),
    .wr_data (wr_data),
    .rd_data (rd_data),
    .irq_src (irq_src),
    .irq_out (irq_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] data;
    logic [7:0]  src;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] data, input logic [7:0] src,
                     input logic [31:0] exp_rd, input logic exp_irq);
    vec_t v;
    v.wr = wr; v.rd = rd; v.addr = addr; v.data = data; v.src = src;
    v.exp_rd = exp_rd; v.exp_irq = exp_irq;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
    end
  endtask

  // Drive one cycle of bus/source activity just after a rising edge and
  // return on the following falling edge, where outputs are sampled.
  task automatic cyc(input logic wr, input logic rd, input logic [31:0] addr,
                     input logic [31:0] data, input logic [7:0] src);
    @(posedge clk);
    #1;
    wr_en = wr; rd_en = rd; address = addr; wr_data = data; irq_src = src;
    @(negedge clk);
  endtask

  // Combinational register read between clock edges (no edge consumed).
  task automatic peek(input logic [31:0] addr, input logic [31:0] exp, input string name);
    wr_en = 1'b0; rd_en = 1'b1; address = addr;
    #0.5;
    check(name, rd_data, exp);
    rd_en = 1'b0;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // ---- reset with all sources high ----
    irq_src = 8'hFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset irq_out", {31'b0, irq_out}, 32'h0);
    check("reset rd_data idle", rd_data, 32'h0);
    peek(A_EN, 32'h0, "reset ENABLE");
    peek(A_TR, 32'h0, "reset TRIGGER");
    peek(A_PD, 32'h0, "reset PENDING");
    peek(A_CL, 32'h0, "reset CLAIM");
    peek(A_IS, 32'h0, "reset INSERV");
    @(posedge clk);
    #1;
    irq_src = 8'h00;
    rst = 1'b1;

    // ---- vector table: wr rd addr data src exp_rd exp_irq ----
    // edge-mode claim/complete on source 0
    add(1,0,A_TR,32'h01,8'h00,32'h0,0);
    add(1,0,A_EN,32'h01,8'h00,32'h0,0);
    add(0,0,A_EN,32'h00,8'h01,32'h0,0);   // one-cycle pulse
    add(0,1,A_PD,32'h00,8'h00,32'h01,0);  // pending, irq not yet
    add(0,1,A_CL,32'h00,8'h00,32'h1,1);   // irq up; claim id 1
    add(0,1,A_IS,32'h00,8'h00,32'h01,1);
    add(0,1,A_IS,32'h00,8'h00,32'h01,0);  // irq drops
    add(1,0,A_CO,32'h01,8'h00,32'h0,0);
    add(0,1,A_IS,32'h00,8'h00,32'h00,0);
    // level-mode priority, sources 2 and 3
    add(1,0,A_TR,32'h00,8'h00,32'h0,0);
    add(1,0,A_EN,32'h0C,8'h0C,32'h0,0);
    add(0,1,A_CL,32'h00,8'h0C,32'h3,0);
    add(0,1,A_IS,32'h00,8'h0C,32'h04,1);
    add(1,0,A_CO,32'h03,8'h0C,32'h0,1);
    add(0,1,A_CL,32'h00,8'h08,32'h3,1);   // re-pended; src 2 drops here
    add(1,0,A_CO,32'h03,8'h08,32'h0,1);
    add(0,1,A_CL,32'h00,8'h08,32'h4,1);
    add(0,1,A_IS,32'h00,8'h00,32'h08,1);
    add(1,0,A_CO,32'h04,8'h00,32'h0,0);
    add(1,0,A_PD,32'h08,8'h00,32'h0,0);
    add(1,0,A_EN,32'h00,8'h00,32'h0,1);
    // masking on source 5
    add(1,0,A_TR,32'h20,8'h00,32'h0,0);
    add(0,0,A_EN,32'h00,8'h20,32'h0,0);
    add(0,1,A_PD,32'h00,8'h00,32'h20,0);
    add(1,0,A_EN,32'h20,8'h00,32'h0,0);
    add(0,0,A_EN,32'h00,8'h00,32'h0,0);
    add(1,0,A_PD,32'h20,8'h00,32'h0,1);
    add(0,1,A_PD,32'h00,8'h00,32'h00,1);
    add(0,0,A_EN,32'h00,8'h00,32'h0,0);
    // collisions on source 1 (edge mode)
    add(1,0,A_TR,32'h02,8'h00,32'h0,0);
    add(1,0,A_EN,32'h02,8'h00,32'h0,0);
    add(0,0,A_EN,32'h00,8'h02,32'h0,0);
    add(0,1,A_PD,32'h00,8'h00,32'h02,0);
    add(0,1,A_CL,32'h00,8'h02,32'h2,1);   // claim + new edge
    add(0,1,A_PD,32'h00,8'h00,32'h02,1);  // set won
    add(0,1,A_IS,32'h00,8'h00,32'h02,0);
    add(1,0,A_CO,32'h00,8'h00,32'h0,0);   // id 0 ignored
    add(1,0,A_CO,32'h09,8'h00,32'h0,0);   // id 9 ignored
    add(0,1,A_IS,32'h00,8'h00,32'h02,0);
    add(0,1,A_PD,32'h00,8'h00,32'h02,0);
    add(1,0,A_CO,32'h02,8'h00,32'h0,0);
    add(0,1,A_CL,32'h00,8'h00,32'h2,0);   // edge seen in service now reported
    add(0,1,A_IS,32'h00,8'h00,32'h02,1);
    add(1,0,A_CO,32'h02,8'h00,32'h0,0);
    add(0,0,A_EN,32'h00,8'h02,32'h0,0);
    add(0,1,A_PD,32'h00,8'h00,32'h02,0);
    add(1,0,A_PD,32'h02,8'h02,32'h0,1);   // W1C + new edge
    add(0,1,A_PD,32'h00,8'h00,32'h02,1);  // set won
    add(1,0,A_PD,32'h02,8'h00,32'h0,1);
    add(0,1,A_PD,32'h00,8'h00,32'h00,1);
    // decode corners
    add(1,1,A_EN,32'h1FF,8'h00,32'h02,0); // rd+wr: old value read
    add(0,1,A_EN,32'h00,8'h00,32'hFF,0);  // upper write bits dropped
    add(1,1,32'h18,32'hFFFF,8'h00,32'h0,0);
    add(0,1,32'h20,32'h00,8'h00,32'hFF,0);  // aliases ENABLE
    add(0,1,A_CO,32'h00,8'h00,32'h0,0);   // write-only reads 0
    add(0,1,A_CL,32'h00,8'h00,32'h0,0);   // nothing to claim
    add(0,1,A_IS,32'h00,8'h00,32'h0,0);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].wr, vecs[i].rd, vecs[i].addr, vecs[i].data, vecs[i].src);
      $display("[TB] vec %0d wr=%0b rd=%0b addr=%02h data=%0h src=%02h rd_data=%0h irq=%0b",
               i, vecs[i].wr, vecs[i].rd, vecs[i].addr[7:0], vecs[i].data,
               vecs[i].src, rd_data, irq_out);
      check($sformatf("vec%0d rd_data", i), rd_data, vecs[i].exp_rd);
      check($sformatf("vec%0d irq_out", i), {31'b0, irq_out}, {31'b0, vecs[i].exp_irq});
    end

    // ---- asynchronous reset while source 0 is in service ----
    cyc(1, 0, A_TR, 32'h00, 8'h00);
    cyc(0, 0, A_EN, 32'h00, 8'h01);
    cyc(0, 1, A_CL, 32'h00, 8'h00);
    check("seq6 claim id", rd_data, 32'h1);
    cyc(0, 1, A_IS, 32'h00, 8'h00);
    check("seq6 inserv", rd_data, 32'h01);
    check("seq6 irq before reset", {31'b0, irq_out}, 32'h1);
    #0.5;
    rst = 1'b0;
    #0.5;
    check("seq6 irq after async reset", {31'b0, irq_out}, 32'h0);
    peek(A_EN, 32'h0, "seq6 ENABLE");
    peek(A_TR, 32'h0, "seq6 TRIGGER");
    peek(A_PD, 32'h0, "seq6 PENDING");
    peek(A_CL, 32'h0, "seq6 CLAIM");
    peek(A_IS, 32'h0, "seq6 INSERV");
    check("seq6 rd_data idle", rd_data, 32'h0);
    $display("[TB] seq6 async reset mid-service checked");

    // ---- level source still high after reset re-pends next cycle ----
    @(posedge clk);
    #1;
    irq_src = 8'h01;
    rst = 1'b1;
    @(negedge clk);
    peek(A_PD, 32'h0, "post-reset pending before edge");
    @(negedge clk);
    peek(A_PD, 32'h01, "post-reset level re-pend");
    check("post-reset irq masked", {31'b0, irq_out}, 32'h0);
    $display("[TB] post-reset level re-pend checked");
    irq_src = 8'h00;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
